// File: rtl/line_read_buffer.sv
// Single-line read buffer: serves 16-bit reads from a buffered 128-bit line, fetching on miss.
// Optional LINE_BUF_FWD_EN forwards fetched data straight to the response, skipping FILL.
module line_read_buffer (
   input  logic         clk,
   input  logic         rst,
   input  logic         mem_read,
   input  logic [15:0]  mem_address,
   input  logic [1:0]   mem_byte_enable,
   output logic [15:0]  mem_rdata,
   output logic         mem_resp,
   output logic         pmem_read,
   output logic [15:0]  pmem_address,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp,
   input  logic         inval,
   input  logic [15:0]  inval_address
);

   typedef enum logic [1:0] {StIdle, StFetch, StFill, StResp} state_e;

   state_e         r_state;
   logic [127:0]   r_line;
   logic [11:0]    r_tag;
   logic           r_valid;
   logic           r_kill;
   logic [15:1]    r_addr;
   logic [1:0]     r_be;

   logic           w_hit;
   logic           w_inval_line;
   logic           w_inval_fetch;
   logic           w_unused;

   assign w_hit         = r_valid && (r_tag == mem_address[15:4]);
   assign w_inval_line  = inval && (inval_address[15:4] == r_tag);
   assign w_inval_fetch = inval && (inval_address[15:4] == r_addr[15:4]);
   assign w_unused      = ^{mem_address[0], inval_address[3:0]};

   function automatic logic [15:0] f_extract(input logic [127:0] line, input logic [2:0] k,
                                             input logic [1:0] be);
      logic [15:0] w;
      w = line[{k, 4'h0} +: 16];
      case (be)
         2'b11:   f_extract = w;
         2'b01:   f_extract = {8'h00, w[7:0]};
         2'b10:   f_extract = {w[15:8], 8'h00};
         default: f_extract = 16'h0000;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StIdle;
         r_line       <= '0;
         r_tag        <= '0;
         r_valid      <= 1'b0;
         r_kill       <= 1'b0;
         r_addr       <= '0;
         r_be         <= '0;
         mem_rdata    <= '0;
         mem_resp     <= 1'b0;
         pmem_read    <= 1'b0;
         pmem_address <= '0;
      end else begin
         // Lookup in IDLE sees the pre-edge valid, so a same-edge inval still hits.
         if (w_inval_line) r_valid <= 1'b0;
         case (r_state)
            StIdle: begin
               mem_resp <= 1'b0;
               if (mem_read) begin
                  r_addr <= mem_address[15:1];
                  r_be   <= mem_byte_enable;
                  if (w_hit) begin
                     mem_rdata <= f_extract(r_line, mem_address[3:1], mem_byte_enable);
                     mem_resp  <= 1'b1;
                     r_state   <= StResp;
                  end else begin
                     pmem_read    <= 1'b1;
                     pmem_address <= {mem_address[15:4], 4'h0};
                     r_kill       <= 1'b0;
                     r_state      <= StFetch;
                  end
               end
            end
            StFetch: begin
               if (pmem_resp) begin
                  pmem_read <= 1'b0;
                  r_line    <= pmem_rdata;
                  r_tag     <= r_addr[15:4];
                  // An inval landing on the fill edge must also leave the line invalid.
                  r_valid   <= ~(r_kill | w_inval_fetch);
                  r_kill    <= 1'b0;
`ifdef LINE_BUF_FWD_EN
                  mem_rdata <= f_extract(pmem_rdata, r_addr[3:1], r_be);
                  mem_resp  <= 1'b1;
                  r_state   <= StResp;
`else
                  r_state   <= StFill;
`endif
               end else if (w_inval_fetch) begin
                  r_kill <= 1'b1;
               end
            end
            StFill: begin
               mem_rdata <= f_extract(r_line, r_addr[3:1], r_be);
               mem_resp  <= 1'b1;
               r_state   <= StResp;
            end
            StResp: begin
               mem_resp <= 1'b0;
               r_state  <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_line_read_buffer.sv
// Scoreboard bench for line_read_buffer: directed test-plan cases plus randomized reads
// checked against a tag/valid reference model and a synthetic backing memory.
module tb_line_read_buffer;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read;
   logic [15:0]  mem_address;
   logic [1:0]   mem_byte_enable;
   logic [15:0]  mem_rdata;
   logic         mem_resp;
   logic         pmem_read;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;
   logic         inval;
   logic [15:0]  inval_address;

   line_read_buffer dut (
      .clk            (clk),
      .rst            (rst),
      .mem_read       (mem_read),
      .mem_address    (mem_address),
      .mem_byte_enable(mem_byte_enable),
      .mem_rdata      (mem_rdata),
      .mem_resp       (mem_resp),
      .pmem_read      (pmem_read),
      .pmem_address   (pmem_address),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp),
      .inval          (inval),
      .inval_address  (inval_address)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [15:0] exp_q[$];

   // Reference model of buffer contents.
   bit          m_valid = 0;
   logic [11:0] m_tag = '0;

   // Memory responder controls.
   bit          mem_auto = 1;
   bit          stray_pulse = 0;
   int          fetch_delay = 0;
   int          dly_cnt = 0;
   int          fetch_cnt = 0;
   logic [15:0] last_fetch_addr = '0;

   logic [11:0] tag_pool[4] = '{12'h123, 12'h456, 12'h789, 12'habc};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [15:0] mem_word(input logic [11:0] tag, input logic [2:0] k);
      if (tag == 12'h123) return 16'h1000 + {13'd0, k};
      return {tag[7:0], 5'b0, k} ^ {4'h5, tag};
   endfunction

   function automatic logic [127:0] mem_line(input logic [11:0] tag);
      logic [127:0] l;
      for (int k = 0; k < 8; k++) l[16*k +: 16] = mem_word(tag, 3'(k));
      return l;
   endfunction

   function automatic logic [15:0] lanes(input logic [15:0] w, input logic [1:0] be);
      logic [15:0] r;
      r = 16'h0000;
      if (be[0]) r[7:0] = w[7:0];
      if (be[1]) r[15:8] = w[15:8];
      return r;
   endfunction

   // Backing memory: answers fetch_delay cycles after pmem_read is seen.
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         pmem_resp = 1'b0;
         if (stray_pulse) begin
            pmem_rdata  = mem_line(12'hfff);
            pmem_resp   = 1'b1;
            stray_pulse = 0;
         end else if (mem_auto && pmem_read) begin
            if (dly_cnt >= fetch_delay) begin
               pmem_rdata      = mem_line(pmem_address[15:4]);
               pmem_resp       = 1'b1;
               last_fetch_addr = pmem_address;
               fetch_cnt++;
               dly_cnt = 0;
            end else begin
               dly_cnt++;
            end
         end else begin
            dly_cnt = 0;
         end
      end
   end

   // Monitor: every response pops one expected word.
   always @(negedge clk) begin
      if (!rst && mem_resp) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_resp: got rdata %0h expected no response at %0t",
                     mem_rdata, $time);
         end else begin
            chk("rdata", {16'h0, mem_rdata}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   // inv_c: cycle (relative to the request edge) of a one-cycle inval pulse; -1 none,
   // 99 picks a random cycle inside the request.
   task automatic do_read(input logic [15:0] addr, input logic [1:0] be, input int d,
                          input int inv_c_in, input logic [15:0] inv_addr);
      logic [11:0] tag;
      bit          hit;
      bit          got;
      int          exp_lat;
      int          n;
      int          f0;
      int          inv_c;
      tag = addr[15:4];
      hit = m_valid && (m_tag == tag);
`ifdef LINE_BUF_FWD_EN
      exp_lat = hit ? 1 : 2 + d;
`else
      exp_lat = hit ? 1 : 3 + d;
`endif
      inv_c = (inv_c_in == 99) ? int'($urandom_range(0, exp_lat - 1)) : inv_c_in;
      exp_q.push_back(lanes(mem_word(tag, addr[3:1]), be));
      fetch_delay = d;
      f0 = fetch_cnt;
      @(negedge clk);
      mem_read        = 1'b1;
      mem_address     = addr;
      mem_byte_enable = be;
      inval_address   = inv_addr;
      inval           = (inv_c == 0);
      n   = 0;
      got = 0;
      while (n < 40 && !got) begin
         @(negedge clk);
         n++;
         if (mem_resp) got = 1;
         else inval = (n == inv_c);
      end
      mem_read = 1'b0;
      inval    = 1'b0;
      chk("latency", got ? n : 999, exp_lat);
      chk("fetch_count", fetch_cnt - f0, hit ? 0 : 1);
      if (!hit) chk("fetch_addr", {16'h0, last_fetch_addr}, {16'h0, tag, 4'h0});
      if (hit) begin
         if (inv_c >= 0 && inv_addr[15:4] == m_tag) m_valid = 0;
      end else begin
         m_tag   = tag;
         m_valid = !(inv_c >= 1 && inv_addr[15:4] == tag);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          saw;
      logic [15:0] a;
      rst             = 1'b1;
      mem_read        = 1'b0;
      mem_address     = '0;
      mem_byte_enable = '0;
      inval           = 1'b0;
      inval_address   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_mem_resp", mem_resp, 0);
      chk("reset_pmem_read", pmem_read, 0);
      chk("reset_mem_rdata", mem_rdata, 0);
      chk("reset_pmem_address", pmem_address, 0);

      // Cold miss, then hits on all lane patterns.
      do_read(16'h1236, 2'b11, 3, -1, 16'h0);
      do_read(16'h123e, 2'b11, 0, -1, 16'h0);
      do_read(16'h123e, 2'b01, 0, -1, 16'h0);
      do_read(16'h123e, 2'b10, 0, -1, 16'h0);
      do_read(16'h123e, 2'b00, 0, -1, 16'h0);

      // Tag miss and refetch.
      do_read(16'h4560, 2'b11, 1, -1, 16'h0);
      do_read(16'h1230, 2'b11, 2, -1, 16'h0);

      // Invalidate during fetch: data returned, next read misses.
      do_read(16'h4560, 2'b11, 0, -1, 16'h0);
      do_read(16'h1230, 2'b11, 3, 2, 16'h123f);
      do_read(16'h1230, 2'b11, 1, -1, 16'h0);

      // Reset mid-fetch; the stray pmem_resp must be ignored.
      mem_auto = 0;
      @(negedge clk);
      mem_read        = 1'b1;
      mem_address     = 16'h7890;
      mem_byte_enable = 2'b11;
      repeat (2) @(negedge clk);
      chk("midfetch_pmem_read", pmem_read, 1);
      rst = 1'b1;
      #1;
      chk("reset_async_pmem_read", pmem_read, 0);
      chk("reset_async_mem_resp", mem_resp, 0);
      mem_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_valid = 0;
      @(negedge clk);
      stray_pulse = 1;
      saw = 0;
      repeat (5) begin
         @(negedge clk);
         if (mem_resp || pmem_read) saw = 1;
      end
      chk("stray_pmem_resp_ignored", saw, 0);
      mem_auto = 1;
      do_read(16'h1230, 2'b11, 0, -1, 16'h0);

      // Same-edge inval and lookup: hit, then miss.
      do_read(16'h1234, 2'b10, 0, 0, 16'h1230);
      do_read(16'h1232, 2'b11, 0, -1, 16'h0);

      // Randomized traffic.
      for (int i = 0; i < 150; i++) begin
         a = {tag_pool[$urandom_range(0, 3)], 4'($urandom)};
         if ($urandom_range(0, 2) == 0)
            do_read(a, 2'($urandom), $urandom_range(0, 3), 99,
                    {tag_pool[$urandom_range(0, 3)], 4'($urandom)});
         else
            do_read(a, 2'($urandom), $urandom_range(0, 3), -1, 16'h0);
      end

      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/line_read_buffer.md
# line_read_buffer

Single-line read buffer that serves 16-bit reads out of 128-bit memory lines: extracts the addressed word and byte lanes from a buffered line, or fetches the line from physical memory on a miss. Sits between a read-only requester (instruction fetch or load path) and the physical memory port. It is the read-side counterpart of the line word-merge logic used on the store path.

## Interface
Parameters:
- none; widths fixed by `lc3b_types`: `lc3b_word` 16, `lc3b_burst` 128, `lc3b_cache_offset` 4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  read request; held with stable address/enables until mem_resp
- mem_address  in  16  byte address; tag = [15:4], word select = [3:1], [0] ignored
- mem_byte_enable  in  2  lane select: bit0 = low byte, bit1 = high byte
- mem_rdata  out  16  extracted data, valid while mem_resp = 1
- mem_resp  out  1  one-cycle response pulse
- pmem_read  out  1  line fetch request, held until pmem_resp
- pmem_address  out  16  line-aligned fetch address, [3:0] = 0
- pmem_rdata  in  128  fetched line, valid when pmem_resp = 1
- pmem_resp  in  1  fetch complete, one-cycle pulse
- inval  in  1  invalidate strobe
- inval_address  in  16  address to invalidate; only [15:4] compared

## Operation
- State: line register (128), tag register (12), valid bit, latched request (address, enables), kill flag, FSM.
- FSM states: IDLE, FETCH, FILL, RESP.
- IDLE: on mem_read, latch address and enables; if valid and tag matches, go RESP; otherwise go FETCH.
- FETCH: pmem_read = 1, pmem_address = {latched[15:4], 4'h0}. On pmem_resp: load line register and tag; valid <= ~kill; kill <= 0; go FILL.
- FILL: go RESP.
- RESP: mem_resp = 1, mem_rdata registered; go IDLE.
- Extraction: w = line[16*k +: 16], where k = addr[3:1]. Byte enables select lanes:
  - 11 -> w
  - 01 -> {8'h00, w[7:0]}
  - 10 -> {w[15:8], 8'h00}
  - 00 -> 16'h0000; a response is still issued.
- Invalidation: inval with a tag match clears valid in the same edge. If it matches the in-flight FETCH tag, set kill: the requester still gets the fetched data, but the line stays invalid.
- Simultaneous events:
  - inval and pmem_resp in the same cycle for the same tag: the line is left invalid.
  - inval and hit lookup in IDLE in the same cycle: the lookup uses the pre-edge valid, so it hits.
- pmem_resp outside FETCH is ignored.
- Reset: asynchronously forces IDLE, valid = 0, kill = 0, mem_resp = 0, mem_rdata = 0, pmem_read = 0, pmem_address = 0, line and tag = 0.

## Timing
- Request sampled at edge E.
- Hit: mem_resp high in the cycle after E (latency 1).
- Miss: pmem_read rises in the cycle after E and stays high through the pmem_resp cycle. Let the pmem_resp edge be P; mem_resp is high in cycle P+2 (via FILL).
- Back-to-back: a new mem_read may be sampled in the cycle after mem_resp; minimum 2 cycles per hit.
- pmem_read and mem_resp are register outputs; no combinational paths from inputs to outputs.

## Configuration
- LINE_BUF_FWD_EN defined: FETCH goes directly to RESP on pmem_resp. mem_rdata is extracted from pmem_rdata at that edge, giving mem_resp in cycle P+1. FILL is unreachable. Line, tag and valid updates are unchanged.
- Undefined: the FILL path as described above, with mem_resp in cycle P+2.

## Test plan
- Cold miss:
  - Stimulus: reset, then read 0x1236, enable 11; memory returns line with word k (16'h1000+k) after 3 cycles.
  - Required: pmem_address 0x1230, mem_rdata 0x1003, mem_resp at P+2 (P+1 with LINE_BUF_FWD_EN).
- Hit and lanes:
  - Stimulus: after the cold miss, read 0x123E with enables 11, 01, 10, 00.
  - Required: 0x1007, 0x0007, 0x1000, 0x0000; each response 1 cycle after request, pmem_read never asserted.
- Tag miss:
  - Stimulus: read 0x4560 after the buffer holds 0x1230.
  - Required: new fetch at 0x4560; then read 0x1230 refetches.
- Invalidate during fetch:
  - Stimulus: inval_address 0x123F pulsed while fetching 0x1230.
  - Required: data still returned; the next read of 0x1230 misses.
- Reset mid-fetch:
  - Stimulus: assert rst with pmem_read high, then pulse pmem_resp after release.
  - Required: pmem_read low immediately; stray pmem_resp ignored; no mem_resp; valid = 0.
- Same-cycle inval and hit lookup:
  - Stimulus: read 0x1230 and inval 0x1230 sampled at the same edge.
  - Required: hit response; the following read misses.
